// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control constants and writeback requester indices.
package rf_ctrl_pkg;

    localparam int        RF_AW   = 5;
    localparam int        RF_DW   = 32;
    localparam int        RF_NREG = 32;
    localparam logic [4:0] RF_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_ALU    = 2'd0,
        WB_LOAD   = 2'd1,
        WB_MULDIV = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr+1; ptr follows each accepted grant.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [N-1:0]  valid,
    input  logic          accept,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic [PW-1:0] ptr;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

    // Pointer resets to the last index so requester 0 is searched first.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ptr <= PW'(N - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: round-robin writeback arbitration,
// pending-write scoreboard with WAW reservation stall and decode read-hazard stall.
module rf_write_scheduler
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ready,
    input  logic [AW-1:0]        A1,
    input  logic [AW-1:0]        A2,
    output logic                 stall,
    output logic [AW-1:0]        A3,
    output logic [DW-1:0]        WD3,
    output logic                 WE3,
    output logic [(1<<AW)-1:0]   pending
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] ZERO_A = AW'(RF_ZERO);

    logic [NREQ-1:0]     grant;
    logic [PW-1:0]       grant_idx;
    logic                xfer_p0;
    logic [AW-1:0]       wr_addr_p0;
    logic [DW-1:0]       wr_data_p0;
    logic                rsv_fire;
    logic [(1<<AW)-1:0]  pending_nxt;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .CLK       (CLK),
        .RESET     (RESET),
        .valid     (req_valid),
        .accept    (xfer_p0),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Stage p0: grant and selected requester payload (combinational).
    assign req_ready  = RESET ? grant : '0;
    assign xfer_p0    = |req_ready;
    assign wr_addr_p0 = req_addr[grant_idx*AW +: AW];
    assign wr_data_p0 = req_data[grant_idx*DW +: DW];

    // rsv_ready deliberately ignores a commit clearing the same bit this cycle.
    assign rsv_ready = (rsv_addr == ZERO_A) || !pending[rsv_addr];
    assign rsv_fire  = rsv_valid && rsv_ready && (rsv_addr != ZERO_A);

    // No bypass: a reader stalls through the WE3 cycle as well.
    assign stall = ((A1 != ZERO_A) && pending[A1]) ||
                   ((A2 != ZERO_A) && pending[A2]);

    // A reservation set wins over a commit clear of the same bit.
    always_comb begin
        pending_nxt = pending;
        if (WE3) begin
            pending_nxt[A3] = 1'b0;
        end
        if (rsv_fire) begin
            pending_nxt[rsv_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Stage p1: registered write port and scoreboard.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            WE3     <= 1'b0;
            A3      <= '0;
            WD3     <= '0;
            pending <= '0;
        end else begin
            pending <= pending_nxt;
            if (xfer_p0 && (wr_addr_p0 != ZERO_A)) begin
                WE3 <= 1'b1;
                A3  <= wr_addr_p0;
                WD3 <= wr_data_p0;
            end else begin
                WE3 <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Schedules the single write port of the 32×32 register file among several writeback requesters (ALU, load unit, multiply/divide) using round-robin arbitration. Keeps a pending-write scoreboard of reserved destination registers and raises a read-hazard stall for the decode stage. It sits between the writeback sources and the register file write port (A3/WD3/WE3), and drives that port from registered outputs.

## Interface
- NREQ, 3, number of writeback requesters (2..8)
- DW, 32, data width
- AW, 5, register address width (2^AW registers; register 0 hardwired zero)

- CLK  in  1  clock, rising edge
- RESET  in  1  reset RESET, synchronous, active-low
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*AW  destination of requester i (slice i)
- req_data  in  NREQ*DW  write data of requester i (slice i)
- req_ready  out  NREQ  one-hot grant; transfer on valid&ready at rising edge
- rsv_valid  in  1  decode reserves a destination register
- rsv_addr  in  AW  register to reserve
- rsv_ready  out  1  reservation accepted this cycle
- A1, A2  in  AW  read addresses presented to the register file
- stall  out  1  A1 or A2 has a pending write
- A3  out  AW  write address to the register file
- WD3  out  DW  write data to the register file
- WE3  out  1  write enable to the register file
- pending  out  2^AW  scoreboard bitmap; bit 0 is always 0

## Operation
- Arbitration: round-robin over valid requesters. Search starts at ptr+1 mod NREQ. On a grant, ptr is set to the granted index. Reset ptr = NREQ-1, so requester 0 has first priority.
- At most one req_ready bit is high. req_ready is combinational from req_valid and ptr. When no requester is valid, req_ready = 0.
- Requesters hold valid, addr and data stable until granted. A valid requester is granted within NREQ cycles.
- Accepted transfer to a nonzero address: A3/WD3 load the transfer, and WE3 = 1 for exactly the next cycle.
- Accepted transfer to address 0: consumed with WE3 = 0 and no scoreboard effect.
- Reservation: rsv_ready = (rsv_addr==0) | ~pending[rsv_addr], which is a WAW stall. When rsv_valid & rsv_ready and the address is nonzero, pending[rsv_addr] is set at the edge.
- Commit: at an edge where WE3 = 1, pending[A3] is cleared. A write to a register that is not pending is legal and performed.
- Simultaneous set and clear of the same bit at one edge: the set wins.
  - This cannot arise from one reservation, because rsv_ready is 0 while the bit is pending.
  - rsv_ready does not look ahead to a clear in the same cycle.
- stall = (A1!=0 & pending[A1]) | (A2!=0 & pending[A2]). It is combinational. There is no bypass, so stall stays high through the WE3 cycle.

## Timing
- Reset values: WE3=0, A3=0, WD3=0, pending=0, ptr=NREQ-1. Therefore req_ready=0 until a valid arrives, stall=0 and rsv_ready=1.
- Write latency:
  - Grant at edge N.
  - WE3/A3/WD3 valid in cycle N..N+1.
  - The register file captures at edge N+1, where pending clears.
  - Reader stall deasserts in the cycle after edge N+1.
- Throughput: one write per cycle. Back-to-back grants give continuous WE3.
- Reset asserted mid-operation: at the reset edge, pending is cleared, ptr is restored and WE3 is forced to 0. An in-flight write is dropped. req_ready stays 0 while RESET = 0.
- Same address written by two requesters in consecutive grants: committed in grant order, and the last one wins.

## Structure
- Package rf_ctrl_pkg holds:
  - localparams RF_AW=5, RF_DW=32, RF_NREG=32, RF_ZERO=5'd0
  - the requester index enum: WB_ALU=0, WB_LOAD=1, WB_MULDIV=2
- Sub-module rr_arbiter (parameter N) contains the valid vector, pointer register and one-hot grant, with a grant-accept input to update the pointer.
- The scoreboard, output registers and stall logic live in rf_write_scheduler.

## Test plan
- Reset, then requester 1 writes addr 7 with 0xDEADBEEF.
  - req_ready=3'b010 in the same cycle.
  - Next cycle: WE3=1, A3=7, WD3=0xDEADBEEF.
  - The following cycle: WE3=0.
- All three requesters continuously valid for 6 cycles: grants follow 0,1,2,0,1,2 and WE3 is high every cycle after the first.
- Reserve r5, then present A1=5: stall=1 and a second reservation of r5 gets rsv_ready=0. After requester 0 writes r5, pending[5]=0 and stall=0 one cycle after the WE3 cycle.
- Requester 2 writes addr 0 with 0x1234: req_ready[2]=1, WE3 stays 0 and pending is unchanged. A1=0 with pending all set gives stall=0.
- Grant requester 0 to r9, then assert RESET=0 in the WE3 cycle. Next cycle: WE3=0, pending=0, ptr restored, so requester 0 is granted first after release.
- Reserve r3 while requester 1 (valid, addr 3) is already granted. Commit clears r3, and a new reservation is accepted the cycle after the WE3 cycle.
